// File: rtl/p2_pkg.sv
// -----------------------------------------------------------------------------
// p2_pkg
//
// Shared types for the P2 sequential arithmetic unit and its command driver.
//   op_t    : operation codes understood by P2 (OP_ILL is never forwarded).
//   state_t : command driver FSM states.
// Helper functions classify states so the driver's output decode and the
// watchdog enable read as plain statements of intent.
// -----------------------------------------------------------------------------
package p2_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_ILL  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_X   = 3'd2,
    S_LOAD_X   = 3'd3,
    S_WAIT_Y   = 3'd4,
    S_LOAD_Y   = 3'd5,
    S_WAIT_RDY = 3'd6,
    S_RESP     = 3'd7
  } state_t;

  // States in which the driver is waiting on P2 and the watchdog runs.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_WAIT_X) || (s == S_WAIT_Y) || (s == S_WAIT_RDY);
  endfunction

  // States during which p2_op carries the latched operation.
  function automatic logic drives_op(input state_t s);
    return (s == S_START) || (s == S_WAIT_X) || (s == S_LOAD_X) ||
           (s == S_WAIT_Y) || (s == S_LOAD_Y) || (s == S_WAIT_RDY);
  endfunction

endpackage

// File: rtl/p2_watchdog.sv
// -----------------------------------------------------------------------------
// p2_watchdog
//
// Cycle counter used to bound every wait on P2.
//   clk     : system clock
//   reset   : synchronous, active-high reset (count -> 0)
//   clear   : synchronous clear, wins over enable
//   enable  : count this cycle
//   expired : enable is high and the count has reached LIMIT-1, i.e. this is
//             the LIMIT-th consecutive enabled cycle since the last clear
//
// The counter saturates at LIMIT-1 so it can never wrap back to zero while a
// caller is still holding enable.
// -----------------------------------------------------------------------------
module p2_watchdog #(
  parameter int LIMIT = 1024,
  parameter int CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/p2_cmd_driver.sv
// -----------------------------------------------------------------------------
// p2_cmd_driver
//
// Command-side initiator for the P2 sequential arithmetic unit. Takes one
// (op, X, Y) request, runs the P2 start / load-X / load-Y handshake, waits
// for P2 to finish and returns result, remainder and sign as a response.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both high. A producer holding valid keeps its payload stable until
// that edge; ready never depends combinationally on valid.
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_op, req_x, req_y       : operation and operands
//   rsp_valid/rsp_ready        : response handshake
//   rsp_result, rsp_remainder,
//   rsp_sign, rsp_error        : response payload (data zeroed on error)
//   p2_start, p2_load,
//   p2_op, p2_data             : command outputs to P2
//   p2_loadX, p2_loadY,
//   p2_ready                   : status inputs from P2
//   p2_result, p2_remainder,
//   p2_sign                    : P2 outputs, captured when p2_ready is seen
//   dbg_state                  : current FSM state, for observation only
//
// All outputs are registered: they are computed from the next state at the
// same edge that moves the FSM, so each output lines up with its state.
// -----------------------------------------------------------------------------
module p2_cmd_driver
  import p2_pkg::*;
#(
  parameter int WORD_LENGTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  // request
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [WORD_LENGTH-1:0] req_x,
  input  logic [WORD_LENGTH-1:0] req_y,
  // response
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_LENGTH-1:0] rsp_result,
  output logic [WORD_LENGTH-1:0] rsp_remainder,
  output logic                   rsp_sign,
  output logic                   rsp_error,
  // P2 command side
  output logic                   p2_start,
  output logic                   p2_load,
  output logic [1:0]             p2_op,
  output logic [WORD_LENGTH-1:0] p2_data,
  input  logic                   p2_loadX,
  input  logic                   p2_loadY,
  input  logic                   p2_ready,
  input  logic [WORD_LENGTH-1:0] p2_result,
  input  logic [WORD_LENGTH-1:0] p2_remainder,
  input  logic                   p2_sign,
  // observation
  output logic [2:0]             dbg_state
);

  state_t                 state;
  state_t                 next_state;
  op_t                    op_q;
  logic [WORD_LENGTH-1:0] x_q;
  logic [WORD_LENGTH-1:0] y_q;

  logic                   accept;
  logic                   got_result;
  logic                   wd_clear;
  logic                   wd_enable;
  logic                   wd_expired;
  logic [1:0]             op_now;

  assign dbg_state = state;

  // req_ready is a registered copy of (state == S_IDLE).
  assign accept     = req_valid && req_ready;
  assign got_result = (state == S_WAIT_RDY) && p2_ready;

  // On the accept edge the latched op is not written yet, so the op driven
  // into START comes straight from the request.
  assign op_now = accept ? req_op : op_q;

  // ---------------------------------------------------------------------------
  // Watchdog: restarts on every state change and counts only while waiting.
  // ---------------------------------------------------------------------------
  assign wd_clear  = (next_state != state);
  assign wd_enable = is_wait_state(state);

  p2_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // ---------------------------------------------------------------------------
  // Next-state decode. The awaited input always wins over a same-cycle
  // watchdog expiry; P2 status inputs outside their wait state are ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = (op_t'(req_op) == OP_ILL) ? S_RESP : S_START;
        end
      end
      S_START: begin
        next_state = S_WAIT_X;
      end
      S_WAIT_X: begin
        if (p2_loadX) begin
          next_state = S_LOAD_X;
        end else if (wd_expired) begin
          next_state = S_RESP;
        end
      end
      S_LOAD_X: begin
        next_state = (op_q == OP_SQRT) ? S_WAIT_RDY : S_WAIT_Y;
      end
      S_WAIT_Y: begin
        if (p2_loadY) begin
          next_state = S_LOAD_Y;
        end else if (wd_expired) begin
          next_state = S_RESP;
        end
      end
      S_LOAD_Y: begin
        next_state = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (p2_ready || wd_expired) begin
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, operand latches and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      op_q          <= OP_MUL;
      x_q           <= '0;
      y_q           <= '0;
      req_ready     <= 1'b1;
      p2_start      <= 1'b0;
      p2_load       <= 1'b0;
      p2_op         <= 2'b00;
      p2_data       <= '0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_remainder <= '0;
      rsp_sign      <= 1'b0;
      rsp_error     <= 1'b0;
    end else begin
      state <= next_state;

      if (accept) begin
        op_q <= op_t'(req_op);
        x_q  <= req_x;
        y_q  <= req_y;
      end

      req_ready <= (next_state == S_IDLE);
      p2_start  <= (next_state == S_START);
      p2_load   <= (next_state == S_LOAD_X) || (next_state == S_LOAD_Y);
      p2_op     <= drives_op(next_state) ? op_now : 2'b00;

      // Operands are already latched by the time either wait state is entered.
      unique case (next_state)
        S_WAIT_X, S_LOAD_X: p2_data <= x_q;
        S_WAIT_Y, S_LOAD_Y: p2_data <= y_q;
        default:            p2_data <= '0;
      endcase

      // Response payload is written once on entry to RESP and then held until
      // the handshake; anything but a real P2 completion is an error.
      if ((next_state == S_RESP) && (state != S_RESP)) begin
        rsp_valid <= 1'b1;
        if (got_result) begin
          rsp_result    <= p2_result;
          rsp_remainder <= p2_remainder;
          rsp_sign      <= p2_sign;
          rsp_error     <= 1'b0;
        end else begin
          rsp_result    <= '0;
          rsp_remainder <= '0;
          rsp_sign      <= 1'b0;
          rsp_error     <= 1'b1;
        end
      end else if (next_state == S_IDLE) begin
        rsp_valid     <= 1'b0;
        rsp_result    <= '0;
        rsp_remainder <= '0;
        rsp_sign      <= 1'b0;
        rsp_error     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/p2_cmd_driver.md
# p2_cmd_driver

Command-side initiator for the P2 sequential arithmetic unit. It accepts one operation request (op, X, Y) on a valid/ready interface and runs the P2 operand-loading handshake: start pulse, X load on loadX, Y load on loadY. It then waits for ready, captures result/remainder/sign and returns them on a valid/ready response interface. It sits between a host/register block and the P2 instance, replacing manual start/load stimulus.

## Interface
- WORD_LENGTH, 16, operand/result width
- TIMEOUT_CYCLES, 1024, max cycles spent in any wait state before aborting
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  driver can accept request (high only in IDLE)
- req_op  in  2  operation code (p2_pkg::op_t)
- req_x  in  WORD_LENGTH  first operand
- req_y  in  WORD_LENGTH  second operand
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WORD_LENGTH  captured P2 result
- rsp_remainder  out  WORD_LENGTH  captured P2 remainder
- rsp_sign  out  1  captured P2 sign
- rsp_error  out  1  1 = timeout or illegal op; data fields are 0
- p2_start  out  1  start pulse to P2
- p2_load  out  1  operand load strobe to P2
- p2_op  out  2  op to P2
- p2_data  out  WORD_LENGTH  operand bus to P2
- p2_loadX  in  1  P2 requests X
- p2_loadY  in  1  P2 requests Y
- p2_ready  in  1  P2 result valid
- p2_result, p2_remainder  in  WORD_LENGTH  P2 outputs
- p2_sign  in  1  P2 sign

## Operation
- Op codes: 2'b00 MUL, 2'b01 DIV, 2'b10 SQRT (X only), 2'b11 illegal.
- Request accepted when req_valid && req_ready; op, X and Y are latched into internal registers.
- States: IDLE, START, WAIT_X, LOAD_X, WAIT_Y, LOAD_Y, WAIT_RDY, RESP.
- IDLE: req_ready=1. On accept: illegal op -> RESP with rsp_error=1; otherwise -> START.
- START: p2_start=1 for exactly one cycle; p2_op=latched op from here until leaving WAIT_RDY -> WAIT_X.
- WAIT_X: p2_data=X. On p2_loadX -> LOAD_X.
- LOAD_X: p2_load=1 for one cycle, p2_data=X. Next state is WAIT_RDY for SQRT, otherwise WAIT_Y.
- WAIT_Y: p2_data=Y. On p2_loadY -> LOAD_Y.
- LOAD_Y: p2_load=1 for one cycle, p2_data=Y -> WAIT_RDY.
- WAIT_RDY: on p2_ready, capture result/remainder/sign, rsp_error=0 -> RESP.
- RESP: rsp_valid=1, response fields stable. On rsp_ready -> IDLE.
- Timeout: a cycle counter clears on each state entry and counts in WAIT_X, WAIT_Y and WAIT_RDY. When it reaches TIMEOUT_CYCLES-1 without the awaited input, the FSM goes to RESP with rsp_error=1 and zeroed data.
- p2_loadX/p2_loadY/p2_ready are ignored outside their respective wait states.
- p2_ready seen in WAIT_X/WAIT_Y is ignored (no early completion).

## Timing
- Reset (sync, active-high): state IDLE, counter 0. All outputs 0 except req_ready=1. p2_data=0, p2_op=0.
- reset asserted in any state returns to IDLE on the next edge. Any in-flight op is dropped with no response. The next request asserts p2_start again.
- Accept edge -> p2_start high in the following cycle (1-cycle latency).
- Awaited input high in cycle N -> p2_load high in cycle N+1 (registered); data is valid in the same cycle as load and for the whole wait/load phase.
- p2_ready high in cycle N -> rsp_valid high in cycle N+1.
- Minimum request-to-response time for MUL with P2 responding immediately: 7 cycles.
- A response held under rsp_ready=0 keeps all rsp_* fields stable; no new request is accepted until the handshake completes.
- Only one operation is in flight at a time; no pipelining.

## Structure
- p2_pkg: op_t enum (OP_MUL, OP_DIV, OP_SQRT, OP_ILL) and state_t enum. P2 should import the same op_t.
- Sub-module p2_watchdog: parameterized counter with clear, enable and expire outputs, sized $clog2(TIMEOUT_CYCLES).

## Test plan
- MUL X=2, Y=40; P2 model returns 80 -> one p2_start, two p2_load pulses carrying 2 then 40; rsp_result=80, rsp_error=0.
- DIV X=300, Y=100; model returns 3 rem 0 -> rsp_result=3, rsp_remainder=0; then DIV 2132/40 back-to-back -> result 53, remainder 12.
- SQRT X=144; model asserts no loadY and returns 12 -> exactly one p2_load; rsp_result=12.
- Illegal op 2'b11 -> no p2_start; rsp_valid the cycle after accept with rsp_error=1.
- Model never asserts p2_loadY (TIMEOUT_CYCLES=16) -> rsp_error=1 after 16 WAIT_Y cycles; rsp_result=0.
- rsp_ready held low for 5 cycles with rsp_result=80 -> fields stable and req_ready=0 throughout. Separately, reset during WAIT_RDY -> IDLE next cycle, no rsp_valid.
